line_index_encoder: RTL and testbench

LINE_INDEX_ENCODER -- requirements
Module: line_index_encoder

---
 rtl/line_index_encoder.sv | 156 +++++++++++++++
 tb/tb_line_index_encoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/line_index_encoder.sv
// ---------------------------------------------------------------------------
// line_index_encoder
//
// Purpose:
//   Selects one eligible cache line out of a 64-bit candidate vector and
//   presents its index, a one-hot copy and an "empty" flag through a
//   registered valid/ready output stage. With RR_EN=1 the search starts at a
//   rotating priority pointer so that repeated requests are served fairly.
//   With RR_EN=0 the lowest set bit always wins.
//
// Ports:
//   clk        - sole clock, all state updates on the rising edge
//   rst_n      - asynchronous active-low reset
//   flush      - synchronous clear of the output stage and the pointer
//   in_valid   - in_vec is presented
//   in_ready   - block accepts in_vec this cycle
//   in_vec     - candidate vector, bit i set = line i eligible
//   out_valid  - registered result available
//   out_ready  - consumer takes the result
//   out_idx    - selected cache-line index
//   out_onehot - one-hot of out_idx, all zero when out_empty
//   out_empty  - captured in_vec was all zero
// ---------------------------------------------------------------------------
module line_index_encoder #(
   parameter int RR_EN = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_vec,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [5:0]  out_idx,
   output logic [63:0] out_onehot,
   output logic        out_empty
);

   // Output stage has two states: nothing held, or a result waiting for
   // the consumer.
   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t      state;
   logic [5:0]  ptr;
   logic [5:0]  out_idx_q;
   logic [63:0] out_onehot_q;
   logic        out_empty_q;

   logic        accept;
   logic [5:0]  scan_base;
   logic [127:0] doubled_vec;
   logic [63:0] rotated_vec;
   logic [6:0]  lowest_info;
   logic        enc_found;
   logic [5:0]  enc_offset;
   logic [5:0]  sel_idx;
   logic [63:0] sel_onehot;
   logic [5:0]  next_ptr;

   // Two-level lowest-set-bit search: first find the lowest non-empty group
   // of eight bits, then the lowest bit inside that group. Returns
   // {found, index}. Scanning each loop from the top down means the last
   // hit written is the lowest one.
   function automatic logic [6:0] find_lowest(input logic [63:0] vec);
      logic [7:0] grp_any;
      logic [2:0] grp;
      logic [7:0] grp_bits;
      logic [2:0] bit_pos;
      grp_any = '0;
      for (int g = 0; g < 8; g++) begin
         grp_any[g] = |vec[g*8 +: 8];
      end
      grp = '0;
      for (int g = 7; g >= 0; g--) begin
         if (grp_any[g]) begin
            grp = 3'(g);
         end
      end
      grp_bits = vec[{grp, 3'b000} +: 8];
      bit_pos = '0;
      for (int b = 7; b >= 0; b--) begin
         if (grp_bits[b]) begin
            bit_pos = 3'(b);
         end
      end
      return {|grp_any, grp, bit_pos};
   endfunction

   // The input side is ready whenever the output stage is free or being
   // drained this cycle; flush blocks acceptance outright.
   always_comb begin
      in_ready = !flush && ((state == IDLE) || out_ready);
      accept   = in_valid && in_ready;
   end

   // Round-robin search is done by rotating the candidate vector right so
   // that bit ptr lands at position 0, finding the lowest set bit of the
   // rotated vector, and adding ptr back (mod 64). In fixed-priority mode
   // the rotation amount is simply zero.
   always_comb begin
      scan_base   = (RR_EN != 0) ? ptr : 6'd0;
      doubled_vec = {in_vec, in_vec} >> scan_base;
      rotated_vec = doubled_vec[63:0];
      lowest_info = find_lowest(rotated_vec);
      enc_found   = lowest_info[6];
      enc_offset  = lowest_info[5:0];
      sel_idx     = enc_found ? (enc_offset + scan_base) : 6'd0;
      sel_onehot  = enc_found ? (64'h1 << sel_idx) : 64'h0;
      next_ptr    = sel_idx + 6'd1;
   end

   // Single sequential block for the state, the pointer and the registered
   // result. Flush takes priority over everything else. An accept either
   // fills an idle stage or replaces a result being drained (back-to-back).
   // Without an accept, a drained result returns the stage to IDLE and an
   // un-drained one is held untouched. The pointer only advances on a
   // non-empty accept in round-robin mode, so it stays at zero otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         ptr          <= '0;
         out_idx_q    <= '0;
         out_onehot_q <= '0;
         out_empty_q  <= 1'b0;
      end else if (flush) begin
         state        <= IDLE;
         ptr          <= '0;
         out_idx_q    <= '0;
         out_onehot_q <= '0;
         out_empty_q  <= 1'b0;
      end else if (accept) begin
         state        <= HOLD;
         out_idx_q    <= sel_idx;
         out_onehot_q <= sel_onehot;
         out_empty_q  <= !enc_found;
         if ((RR_EN != 0) && enc_found) begin
            ptr <= next_ptr;
         end
      end else if ((state == HOLD) && out_ready) begin
         state <= IDLE;
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      out_valid  = (state == HOLD);
      out_idx    = out_idx_q;
      out_onehot = out_onehot_q;
      out_empty  = out_empty_q;
   end

endmodule

// File: tb/tb_line_index_encoder.sv
// ---------------------------------------------------------------------------
// tb_line_index_encoder
//
// Purpose:
//   Directed self-checking bench for line_index_encoder. A round-robin
//   instance and a fixed-priority instance share all inputs; each phase
//   checks the instance it is about.
// ---------------------------------------------------------------------------
module tb_line_index_encoder;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [63:0] in_vec;
   logic        out_ready;

   logic        in_ready;
   logic        out_valid;
   logic [5:0]  out_idx;
   logic [63:0] out_onehot;
   logic        out_empty;

   logic        fx_in_ready;
   logic        fx_out_valid;
   logic [5:0]  fx_out_idx;
   logic [63:0] fx_out_onehot;
   logic        fx_out_empty;

   int checks = 0;
   int errors = 0;

   line_index_encoder #(.RR_EN(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_vec     (in_vec),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_idx    (out_idx),
      .out_onehot (out_onehot),
      .out_empty  (out_empty)
   );

   line_index_encoder #(.RR_EN(0)) dut_fixed (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (fx_in_ready),
      .in_vec     (in_vec),
      .out_valid  (fx_out_valid),
      .out_ready  (out_ready),
      .out_idx    (fx_out_idx),
      .out_onehot (fx_out_onehot),
      .out_empty  (fx_out_empty)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compares one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Drives the shared input signals.
   task automatic applyStimulus(input logic valid, input logic [63:0] vec,
                                input logic ready);
      in_valid  = valid;
      in_vec    = vec;
      out_ready = ready;
   endtask

   // Advances to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accepts one vector with the consumer ready and checks the RR result.
   task automatic acceptAndCheck(input string tag, input logic [63:0] vec,
                                 input logic [5:0] exp_idx);
      applyStimulus(1'b1, vec, 1'b1);
      tick();
      checkOutput({tag, "_valid"}, 64'(out_valid), 64'h1);
      checkOutput({tag, "_idx"}, 64'(out_idx), 64'(exp_idx));
      checkOutput({tag, "_onehot"}, out_onehot, 64'h1 << exp_idx);
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      applyStimulus(1'b0, 64'h0, 1'b0);
      repeat (3) tick();

      // Reset state
      checkOutput("rst_valid", 64'(out_valid), 64'h0);
      checkOutput("rst_idx", 64'(out_idx), 64'h0);
      checkOutput("rst_onehot", out_onehot, 64'h0);
      checkOutput("rst_empty", 64'(out_empty), 64'h0);
      rst_n = 1'b1;
      #1;
      checkOutput("rst_in_ready", 64'(in_ready), 64'h1);

      // Round-robin basics and pointer wrap (ptr: 0->1->0->1->1)
      acceptAndCheck("rr_first", 64'h1, 6'd0);
      acceptAndCheck("rr_wrap63", 64'h8000_0000_0000_0001, 6'd63);
      acceptAndCheck("rr_ptr0", 64'h3, 6'd0);
      acceptAndCheck("rr_scanwrap", 64'h1, 6'd0);

      // Empty vector: ptr stays at 1
      applyStimulus(1'b1, 64'h0, 1'b1);
      tick();
      checkOutput("empty_valid", 64'(out_valid), 64'h1);
      checkOutput("empty_flag", 64'(out_empty), 64'h1);
      checkOutput("empty_idx", 64'(out_idx), 64'h0);
      checkOutput("empty_onehot", out_onehot, 64'h0);
      acceptAndCheck("ptr_kept", 64'h3, 6'd1);

      // Single-bit vectors pick that bit wherever ptr is (ptr 2 then 41)
      acceptAndCheck("single40", 64'h1 << 40, 6'd40);
      acceptAndCheck("single10", 64'h1 << 10, 6'd10);

      // Backpressure: idx 5 held for 3 cycles, ptr becomes 6
      acceptAndCheck("bp_load", 64'h20, 6'd5);
      applyStimulus(1'b1, 64'hFFFF, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput("bp_in_ready", 64'(in_ready), 64'h0);
         tick();
         checkOutput("bp_valid", 64'(out_valid), 64'h1);
         checkOutput("bp_idx", 64'(out_idx), 64'h5);
         checkOutput("bp_onehot", out_onehot, 64'h20);
      end
      out_ready = 1'b1;
      #1;
      checkOutput("bp_release_ready", 64'(in_ready), 64'h1);
      tick();
      checkOutput("bp_new_idx", 64'(out_idx), 64'h6);

      // Drain to IDLE
      applyStimulus(1'b0, 64'h0, 1'b1);
      tick();
      checkOutput("drain_valid", 64'(out_valid), 64'h0);

      // Flush in HOLD with a pending input (ptr 7 -> scan wraps to bit 2)
      acceptAndCheck("pre_flush", 64'h4, 6'd2);
      flush = 1'b1;
      applyStimulus(1'b1, 64'hFF, 1'b1);
      #1;
      checkOutput("flush_in_ready", 64'(in_ready), 64'h0);
      tick();
      checkOutput("flush_valid", 64'(out_valid), 64'h0);
      flush = 1'b0;

      // Streaming from ptr 0 proves the flush cleared the pointer
      applyStimulus(1'b1, 64'hFF, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("stream_valid", 64'(out_valid), 64'h1);
         checkOutput("stream_idx", 64'(out_idx), 64'(i));
      end
      applyStimulus(1'b0, 64'h0, 1'b1);
      tick();
      checkOutput("stream_end", 64'(out_valid), 64'h0);

      // Asynchronous reset mid-HOLD
      acceptAndCheck("pre_reset", 64'h1 << 20, 6'd20);
      applyStimulus(1'b0, 64'h0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_valid", 64'(out_valid), 64'h0);
      checkOutput("async_idx", 64'(out_idx), 64'h0);
      checkOutput("async_onehot", out_onehot, 64'h0);
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("post_rst_valid", 64'(out_valid), 64'h0);
      checkOutput("post_rst_ready", 64'(in_ready), 64'h1);

      // Fixed-priority instance: lowest bit always wins
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 64'hF0, 1'b1);
         tick();
         checkOutput("fixed_valid", 64'(fx_out_valid), 64'h1);
         checkOutput("fixed_idx", 64'(fx_out_idx), 64'h4);
         checkOutput("fixed_onehot", fx_out_onehot, 64'h10);
      end
      applyStimulus(1'b1, 64'h8000_0000_0000_0001, 1'b1);
      tick();
      checkOutput("fixed_low", 64'(fx_out_idx), 64'h0);
      applyStimulus(1'b1, 64'h0, 1'b1);
      tick();
      checkOutput("fixed_empty", 64'(fx_out_empty), 64'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
